// File: rtl/processor_load_ctrl.sv
// processor_load_ctrl
//   Host-facing sequencer for processor_top. Takes a command stream of
//   instruction words, data words, START and ABORT. While the CPU is held in
//   reset it drives the instr/data write ports. START releases reset, and the
//   block then supervises the run until done, timeout or abort. The CPU's
//   output is captured into a result register when done is seen.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     defined   : checksum accumulates every written word (mod 2^DATA_W)
//                 and is cleared on reset and on START accept.
//     undefined : checksum is tied to 0 and no adder is built.
//
// Ports
//   clk, rst          clock (rising edge); async active-low reset
//   cmd_valid/ready   host command handshake; cmd_kind 0 INSTR 1 DATA 2 START 3 ABORT
//   cmd_addr/data     word address and word for INSTR/DATA
//   cycle_limit       max RUN cycles (0 = unlimited), sampled at START accept
//   cpu_rst           active-high reset to processor_top
//   instr/instr_addr/ins_we, data/data_addr/data_we   memory write ports
//   processor_out, done                               from processor_top
//   result/result_valid, timeout, busy, run_cycles, checksum   status
module processor_load_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_kind,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_data,
  input  logic [TIMEOUT_W-1:0] cycle_limit,
  output logic                 cpu_rst,
  output logic [DATA_W-1:0]    instr,
  output logic [ADDR_W-1:0]    instr_addr,
  output logic                 ins_we,
  output logic [DATA_W-1:0]    data,
  output logic [ADDR_W-1:0]    data_addr,
  output logic                 data_we,
  input  logic [DATA_W-1:0]    processor_out,
  input  logic                 done,
  output logic [DATA_W-1:0]    result,
  output logic                 result_valid,
  output logic                 timeout,
  output logic                 busy,
  output logic [TIMEOUT_W-1:0] run_cycles,
  output logic [DATA_W-1:0]    checksum
);

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_RELEASE, S_RUN} state_t;

  localparam logic [1:0] K_INSTR = 2'd0;
  localparam logic [1:0] K_DATA  = 2'd1;
  localparam logic [1:0] K_START = 2'd2;
  localparam logic [1:0] K_ABORT = 2'd3;

  state_t                state, state_nxt;
  logic                  ready_en;   // holds cmd_ready low until the first clock after reset
  logic                  accept;
  logic                  start_acc;
  logic                  hit_limit;
  logic [TIMEOUT_W-1:0]  limit_q;
  logic [TIMEOUT_W:0]    run_inc;

  assign accept    = cmd_valid && cmd_ready;
  assign start_acc = accept && (state == S_LOAD) && (cmd_kind == K_START);

  // Extra bit keeps the compare honest when run_cycles is saturated.
  assign run_inc   = {1'b0, run_cycles} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign hit_limit = (limit_q != '0) && (run_inc == {1'b0, limit_q});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_rst   = 1'b1;
    busy      = 1'b1;
    cmd_ready = 1'b0;
    case (state)
      S_LOAD: begin
        busy      = 1'b0;
        cmd_ready = ready_en;
        if (accept) begin
          if (cmd_kind == K_INSTR || cmd_kind == K_DATA) state_nxt = S_WRITE;
          else if (cmd_kind == K_START)                  state_nxt = S_RELEASE;
        end
      end
      S_WRITE: state_nxt = S_LOAD;
      S_RELEASE: begin
        cpu_rst   = 1'b0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        cpu_rst   = 1'b0;
        cmd_ready = ready_en && (cmd_kind == K_ABORT);
        // done, limit and an accepted abort all end the run; flags sort out priority.
        if (done || hit_limit || accept) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en     <= 1'b0;
      instr        <= '0;
      instr_addr   <= '0;
      ins_we       <= 1'b0;
      data         <= '0;
      data_addr    <= '0;
      data_we      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      run_cycles   <= '0;
      limit_q      <= '0;
    end else begin
      ready_en <= 1'b1;
      // Write enables are single-cycle pulses that coincide with S_WRITE.
      ins_we   <= 1'b0;
      data_we  <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept) begin
            case (cmd_kind)
              K_INSTR: begin
                instr      <= cmd_data;
                instr_addr <= cmd_addr;
                ins_we     <= 1'b1;
              end
              K_DATA: begin
                data      <= cmd_data;
                data_addr <= cmd_addr;
                data_we   <= 1'b1;
              end
              K_START: begin
                result_valid <= 1'b0;
                timeout      <= 1'b0;
                run_cycles   <= '0;
                limit_q      <= cycle_limit;
              end
              default: begin
                result_valid <= 1'b0;
                timeout      <= 1'b0;
              end
            endcase
          end
        end
        S_RUN: begin
          if (!(&run_cycles)) run_cycles <= run_inc[TIMEOUT_W-1:0];
          if (done) begin
            result       <= processor_out;
            result_valid <= 1'b1;
          end else if (hit_limit) begin
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           checksum <= '0;
    else if (start_acc) checksum <= '0;
    else if (ins_we)    checksum <= checksum + instr;
    else if (data_we)   checksum <= checksum + data;
  end
`else
  assign checksum = '0;
`endif

endmodule
